eeg_pea_eng_seq: RTL and testbench

Sequencer that feeds one EEG PE convolution engine. On a start pulse it latches a job descriptor and waits for the PE to report idle. It then walks activation RAM (outer loop) and weight RAM (inner loop), and streams {act, wei, act index, wei index, last flags} into the PE's valid/ready input. It reports done once the PE has drained its partial sums and returned to idle.

---
 rtl/eeg_pea_eng_seq_pkg.sv | 40 ++++
 rtl/eeg_pea_eng_seq_if.sv | 33 +++
 rtl/eeg_pea_eng_seq_fifo.sv | 56 +++++
 rtl/eeg_pea_eng_seq.sv | 171 +++++++++++++++++
 tb/tb_eeg_pea_eng_seq.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/eeg_pea_eng_seq_pkg.sv
// Shared types for the EEG PE sequencer: FSM encoding, beat sideband,
// FIFO entry layout and default widths.
package eeg_pea_pkg;

  // Default widths; the sideband and FIFO entry layouts below are built from
  // these, so instances must keep their width parameters at these values.
  localparam int DEF_ACT_DW      = 8;
  localparam int DEF_WEI_DW      = 8;
  localparam int DEF_ARAM_ADD_AW = 10;
  localparam int DEF_WRAM_ADD_AW = 8;
  localparam int DEF_CONV_WEI_DW = 3;

  // The read credit is sized for exactly this depth.
  localparam int FIFO_DEPTH = 2;

  // One-hot FSM encoding.
  localparam int ST_W = 5;
  typedef logic [ST_W-1:0] state_t;
  localparam state_t S_IDLE  = 5'b00001;
  localparam state_t S_WAIT  = 5'b00010;
  localparam state_t S_RUN   = 5'b00100;
  localparam state_t S_DRAIN = 5'b01000;
  localparam state_t S_FIN   = 5'b10000;

  // Per-beat sideband that travels alongside the RAM read.
  typedef struct packed {
    logic [DEF_ARAM_ADD_AW-1:0] act_idx;
    logic [DEF_CONV_WEI_DW-1:0] wei_idx;
    logic                       act_lst;
    logic                       wei_lst;
  } sideband_t;

  // One FIFO entry: RAM data plus its sideband.
  typedef struct packed {
    logic [DEF_ACT_DW-1:0] act_dat;
    logic [DEF_WEI_DW-1:0] wei_dat;
    sideband_t             sb;
  } beat_t;

endpackage

// File: rtl/eeg_pea_eng_seq_if.sv
// Valid/ready stream from the sequencer into the PE, plus the PE idle status.
interface eeg_pea_eng_seq_if #(
  parameter int ACT_DW      = eeg_pea_pkg::DEF_ACT_DW,
  parameter int WEI_DW      = eeg_pea_pkg::DEF_WEI_DW,
  parameter int ARAM_ADD_AW = eeg_pea_pkg::DEF_ARAM_ADD_AW,
  parameter int CONV_WEI_DW = eeg_pea_pkg::DEF_CONV_WEI_DW
) ();

  logic                   PE_IS_IDLE;
  logic                   PE_DIN_VLD;
  logic                   PE_DIN_RDY;
  logic                   PE_ACT_LST;
  logic                   PE_WEI_LST;
  logic [ACT_DW-1:0]      PE_ACT_DAT;
  logic [ARAM_ADD_AW-1:0] PE_ACT_ADD;
  logic [WEI_DW-1:0]      PE_WEI_DAT;
  logic [CONV_WEI_DW-1:0] PE_WEI_IDX;

  // Sequencer side.
  modport master (
    input  PE_IS_IDLE, PE_DIN_RDY,
    output PE_DIN_VLD, PE_ACT_LST, PE_WEI_LST,
           PE_ACT_DAT, PE_ACT_ADD, PE_WEI_DAT, PE_WEI_IDX
  );

  // PE side.
  modport slave (
    output PE_IS_IDLE, PE_DIN_RDY,
    input  PE_DIN_VLD, PE_ACT_LST, PE_WEI_LST,
           PE_ACT_DAT, PE_ACT_ADD, PE_WEI_DAT, PE_WEI_IDX
  );

endinterface

// File: rtl/eeg_pea_eng_seq_fifo.sv
// Two-entry synchronous FIFO that decouples RAM read latency from PE backpressure.
module eeg_pea_eng_seq_fifo
  import eeg_pea_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [FIFO_DEPTH];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_count;
  logic         w_pop;

  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rptr];

  // Storage, pointers and occupancy; push into a full FIFO is legal only alongside a pop.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the two entries are reset because the head drives PE payload outputs that must read 0 after reset.
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      unique case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && o_full && !w_pop));

endmodule

// File: rtl/eeg_pea_eng_seq.sv
// Sequencer feeding one EEG PE: walks activation (outer) x weight (inner) RAM
// and streams beats with index/last sideband into the PE valid/ready input.
module eeg_pea_eng_seq
  import eeg_pea_pkg::*;
#(
  parameter int ACT_DW      = DEF_ACT_DW,
  parameter int WEI_DW      = DEF_WEI_DW,
  parameter int ARAM_ADD_AW = DEF_ARAM_ADD_AW,
  parameter int WRAM_ADD_AW = DEF_WRAM_ADD_AW,
  parameter int CONV_WEI_DW = DEF_CONV_WEI_DW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   CTRL_START,
  output logic                   CTRL_BUSY,
  output logic                   CTRL_DONE,
  input  logic [ARAM_ADD_AW-1:0] CFG_ACT_BASE,
  input  logic [ARAM_ADD_AW-1:0] CFG_ACT_LST,
  input  logic [WRAM_ADD_AW-1:0] CFG_WEI_BASE,
  input  logic [CONV_WEI_DW-1:0] CFG_WEI_LST,
  output logic                   ARAM_REN,
  output logic [ARAM_ADD_AW-1:0] ARAM_RADD,
  input  logic [ACT_DW-1:0]      ARAM_RDAT,
  output logic                   WRAM_REN,
  output logic [WRAM_ADD_AW-1:0] WRAM_RADD,
  input  logic [WEI_DW-1:0]      WRAM_RDAT,
  eeg_pea_eng_seq_if.master      pe
);

  state_t                 r_state;
  state_t                 w_next;

  logic [ARAM_ADD_AW-1:0] r_act_base;
  logic [ARAM_ADD_AW-1:0] r_act_lst;
  logic [WRAM_ADD_AW-1:0] r_wei_base;
  logic [CONV_WEI_DW-1:0] r_wei_lst;
  logic [ARAM_ADD_AW-1:0] r_act_cnt;
  logic [CONV_WEI_DW-1:0] r_wei_cnt;

  logic                   r_rd_vld;   // read issued last cycle; data arrives this cycle
  sideband_t              r_rd_sb;
  logic                   r_hs_d;     // PE handshake happened last cycle

  logic                   w_start_acc;
  logic                   w_issue;
  logic                   w_credit;
  logic                   w_wei_last;
  logic                   w_act_last;
  logic                   w_pop;
  logic [2:0]             w_occ;

  beat_t                  w_push_beat;
  beat_t                  w_head;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [1:0]             w_fifo_count;

  assign w_start_acc = (r_state == S_IDLE) && CTRL_START;
  assign w_wei_last  = (r_wei_cnt == r_wei_lst);
  assign w_act_last  = (r_act_cnt == r_act_lst);
  assign w_pop       = !w_fifo_empty && pe.PE_DIN_RDY;

  // Occupancy after this cycle's pop, counting the read already in flight.
  // Crediting the pop lets a new read go out every cycle while the PE accepts.
  assign w_occ    = {1'b0, w_fifo_count} + {2'b00, r_rd_vld} - {2'b00, w_pop};
  assign w_credit = (w_occ < 3'(FIFO_DEPTH));

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // FSM next-state logic.
  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (CTRL_START) w_next = S_WAIT;
      S_WAIT:  if (pe.PE_IS_IDLE) w_next = S_RUN;
      S_RUN:   if (w_issue && w_act_last && w_wei_last) w_next = S_DRAIN;
      // Idle is trusted only two or more cycles after the last handshake,
      // once the PE has had time to register that beat.
      S_DRAIN: if (w_fifo_empty && !r_rd_vld && !r_hs_d && pe.PE_IS_IDLE) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM outputs: status, read issue and RAM addressing.
  always_comb begin
    CTRL_BUSY = (r_state != S_IDLE);
    CTRL_DONE = (r_state == S_FIN);
    w_issue   = (r_state == S_RUN) && w_credit;
    ARAM_REN  = w_issue;
    WRAM_REN  = w_issue;
    ARAM_RADD = '0;
    WRAM_RADD = '0;
    if (w_issue) begin
      ARAM_RADD = r_act_base + r_act_cnt;
      WRAM_RADD = r_wei_base + {{(WRAM_ADD_AW-CONV_WEI_DW){1'b0}}, r_wei_cnt};
    end
  end

  // Job shadow registers, loop counters and the one-cycle sideband delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_base <= '0;
      r_act_lst  <= '0;
      r_wei_base <= '0;
      r_wei_lst  <= '0;
      r_act_cnt  <= '0;
      r_wei_cnt  <= '0;
      r_rd_vld   <= 1'b0;
      r_rd_sb    <= '0;
      r_hs_d     <= 1'b0;
    end else begin
      if (w_start_acc) begin
        r_act_base <= CFG_ACT_BASE;
        r_act_lst  <= CFG_ACT_LST;
        r_wei_base <= CFG_WEI_BASE;
        r_wei_lst  <= CFG_WEI_LST;
        r_act_cnt  <= '0;
        r_wei_cnt  <= '0;
      end else if (w_issue) begin
        if (w_wei_last) begin
          r_wei_cnt <= '0;
          r_act_cnt <= r_act_cnt + ARAM_ADD_AW'(1);
        end else begin
          r_wei_cnt <= r_wei_cnt + CONV_WEI_DW'(1);
        end
      end
      r_rd_vld <= w_issue;
      if (w_issue) begin
        r_rd_sb <= '{act_idx: r_act_cnt,
                     wei_idx: r_wei_cnt,
                     act_lst: w_act_last && w_wei_last,
                     wei_lst: w_wei_last};
      end
      r_hs_d <= w_pop;
    end
  end

  assign w_push_beat = '{act_dat: ARAM_RDAT, wei_dat: WRAM_RDAT, sb: r_rd_sb};

  eeg_pea_eng_seq_fifo #(
    .W ($bits(beat_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_rd_vld),
    .i_din   (w_push_beat),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign pe.PE_DIN_VLD = !w_fifo_empty;
  assign pe.PE_ACT_DAT = w_head.act_dat;
  assign pe.PE_WEI_DAT = w_head.wei_dat;
  assign pe.PE_ACT_ADD = w_head.sb.act_idx;
  assign pe.PE_WEI_IDX = w_head.sb.wei_idx;
  assign pe.PE_ACT_LST = w_head.sb.act_lst;
  assign pe.PE_WEI_LST = w_head.sb.wei_lst;

  a_credit_holds: assert property (@(posedge clk) disable iff (!rst_n)
    !(r_rd_vld && w_fifo_full && !w_pop));

endmodule

// File: tb/tb_eeg_pea_eng_seq.sv
// Directed bench for eeg_pea_eng_seq with RAM and PE behavioural models.
module tb_eeg_pea_eng_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ctrl_start, ctrl_busy, ctrl_done;
  logic [9:0] cfg_act_base, cfg_act_lst;
  logic [7:0] cfg_wei_base;
  logic [2:0] cfg_wei_lst;
  logic       aram_ren, wram_ren;
  logic [9:0] aram_radd;
  logic [7:0] wram_radd;
  logic [7:0] aram_rdat = '0, wram_rdat = '0;
  logic       rdy, force_busy;

  always #5 clk = ~clk;

  eeg_pea_eng_seq_if #(.ACT_DW(8), .WEI_DW(8), .ARAM_ADD_AW(10), .CONV_WEI_DW(3)) pe_if ();

  eeg_pea_eng_seq #(
    .ACT_DW(8), .WEI_DW(8), .ARAM_ADD_AW(10), .WRAM_ADD_AW(8), .CONV_WEI_DW(3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .CTRL_START   (ctrl_start),
    .CTRL_BUSY    (ctrl_busy),
    .CTRL_DONE    (ctrl_done),
    .CFG_ACT_BASE (cfg_act_base),
    .CFG_ACT_LST  (cfg_act_lst),
    .CFG_WEI_BASE (cfg_wei_base),
    .CFG_WEI_LST  (cfg_wei_lst),
    .ARAM_REN     (aram_ren),
    .ARAM_RADD    (aram_radd),
    .ARAM_RDAT    (aram_rdat),
    .WRAM_REN     (wram_ren),
    .WRAM_RADD    (wram_radd),
    .WRAM_RDAT    (wram_rdat),
    .pe           (pe_if)
  );

  // RAM models: registered read, data one cycle after enable.
  logic [7:0] aram [1024];
  logic [7:0] wram [256];
  initial begin
    for (int i = 0; i < 1024; i++) aram[i] = 8'(i * 7 + 3);
    for (int i = 0; i < 256; i++)  wram[i] = 8'(i) ^ 8'hA5;
  end
  always @(posedge clk) begin
    if (aram_ren) aram_rdat <= aram[aram_radd];
    if (wram_ren) wram_rdat <= wram[wram_radd];
  end

  // PE model: busy for 3 cycles after each accepted beat, or while forced.
  int idle_hold;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         idle_hold <= 0;
    else if (pe_if.PE_DIN_VLD && pe_if.PE_DIN_RDY)      idle_hold <= 3;
    else if (idle_hold > 0)                             idle_hold <= idle_hold - 1;
  end
  assign pe_if.PE_IS_IDLE = (idle_hold == 0) && !force_busy;
  assign pe_if.PE_DIN_RDY = rdy;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Checking.
  int n_vec = 0, n_err = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: beats, reads, stalls and done pulses, sampled on the falling edge.
  logic [30:0] w_pay;
  assign w_pay = {pe_if.PE_ACT_ADD, pe_if.PE_WEI_IDX, pe_if.PE_ACT_LST, pe_if.PE_WEI_LST,
                  pe_if.PE_ACT_DAT, pe_if.PE_WEI_DAT};

  logic [30:0] beat_q[$];
  logic [17:0] rd_q[$];
  int first_ren_cyc, first_vld_cyc, last_hs_cyc, done_cnt, done_cyc;
  int stall_err, stall_cnt, drop_err, ren_mis;
  logic        stall_prev;
  logic [30:0] stall_pay;

  always @(negedge clk) begin
    if (rst_n) begin
      if (aram_ren) begin
        rd_q.push_back({aram_radd, wram_radd});
        if (first_ren_cyc < 0) first_ren_cyc = cyc;
      end
      if (aram_ren !== wram_ren) ren_mis++;
      if (stall_prev && !pe_if.PE_DIN_VLD) drop_err++;
      if (pe_if.PE_DIN_VLD) begin
        if (first_vld_cyc < 0) first_vld_cyc = cyc;
        if (stall_prev && w_pay !== stall_pay) stall_err++;
      end
      if (pe_if.PE_DIN_VLD && rdy) begin
        beat_q.push_back(w_pay);
        last_hs_cyc = cyc;
        stall_prev  = 1'b0;
      end else if (pe_if.PE_DIN_VLD) begin
        stall_prev = 1'b1;
        stall_pay  = w_pay;
        stall_cnt++;
      end else begin
        stall_prev = 1'b0;
      end
      if (ctrl_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clear_mon();
    beat_q.delete();
    rd_q.delete();
    first_ren_cyc = -1;
    first_vld_cyc = -1;
    last_hs_cyc   = -1;
    done_cnt = 0; done_cyc = -1;
    stall_err = 0; stall_cnt = 0; drop_err = 0; ren_mis = 0;
    stall_prev = 1'b0;
  endtask

  task automatic start_job(input int ab, input int al, input int wb, input int wl);
    @(posedge clk); #1;
    cfg_act_base = 10'(ab); cfg_act_lst = 10'(al);
    cfg_wei_base = 8'(wb);  cfg_wei_lst = 3'(wl);
    ctrl_start   = 1'b1;
    @(posedge clk); #1;
    ctrl_start   = 1'b0;
    cfg_act_base = 10'h2AA; cfg_act_lst = 10'h155;
    cfg_wei_base = 8'h77;   cfg_wei_lst = 3'd5;
  endtask

  task automatic wait_done(input string nm, input int budget, input bit rnd);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk); #1;
      if (rnd) rdy = 1'($urandom_range(0, 1));
      n++;
    end
    rdy = 1'b1;
    chk({nm, " done_seen"}, 64'(done_cnt != 0), 64'd1);
    chk({nm, " busy_after_done"}, 64'(ctrl_busy), 64'd0);
    repeat (3) begin @(posedge clk); #1; end
    chk({nm, " done_once"}, 64'(done_cnt), 64'd1);
  endtask

  task automatic check_job(input string nm, input int ab, input int al, input int wb, input int wl);
    int nb;
    nb = (al + 1) * (wl + 1);
    chk({nm, " beats"}, 64'(beat_q.size()), 64'(nb));
    chk({nm, " reads"}, 64'(rd_q.size()), 64'(nb));
    for (int i = 0; i < nb; i++) begin
      int a, w;
      logic [9:0]  aa;
      logic [7:0]  wa;
      logic [30:0] ep;
      a  = i / (wl + 1);
      w  = i % (wl + 1);
      aa = 10'(ab + a);
      wa = 8'(wb + w);
      ep = {10'(a), 3'(w), 1'(a == al && w == wl), 1'(w == wl), aram[aa], wram[wa]};
      if (i < beat_q.size()) chk($sformatf("%s beat%0d", nm, i), 64'(beat_q[i]), 64'(ep));
      if (i < rd_q.size())   chk($sformatf("%s raddr%0d", nm, i), 64'(rd_q[i]), 64'({aa, wa}));
    end
    chk({nm, " stall_stable"}, 64'(stall_err), 64'd0);
    chk({nm, " vld_drop"},     64'(drop_err),  64'd0);
    chk({nm, " ren_equal"},    64'(ren_mis),   64'd0);
  endtask

  function automatic logic [63:0] outs_vec();
    return 64'({ctrl_busy, ctrl_done, aram_ren, wram_ren, aram_radd, wram_radd,
                pe_if.PE_DIN_VLD, pe_if.PE_ACT_LST, pe_if.PE_WEI_LST,
                pe_if.PE_ACT_DAT, pe_if.PE_ACT_ADD, pe_if.PE_WEI_DAT, pe_if.PE_WEI_IDX});
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; ctrl_start = 1'b0; rdy = 1'b1; force_busy = 1'b0;
    cfg_act_base = '0; cfg_act_lst = '0; cfg_wei_base = '0; cfg_wei_lst = '0;
    clear_mon();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset outputs", outs_vec(), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic 3x3 job with the PE always ready.
    clear_mon();
    start_job(5, 2, 10, 2);
    wait_done("t1", 500, 1'b0);
    check_job("t1", 5, 2, 10, 2);
    chk("t1 first_vld_latency", 64'(first_vld_cyc - first_ren_cyc), 64'd2);

    // Same job under random backpressure.
    clear_mon();
    start_job(5, 2, 10, 2);
    wait_done("t2", 2000, 1'b1);
    check_job("t2", 5, 2, 10, 2);
    chk("t2 stalls_seen", 64'(stall_cnt > 0), 64'd1);

    // PE not idle for 20 cycles after start.
    clear_mon();
    force_busy = 1'b1;
    start_job(5, 2, 10, 2);
    n = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (!ctrl_busy) n++;
    end
    chk("t3 busy_while_wait", 64'(n), 64'd0);
    chk("t3 no_read_while_wait", 64'(rd_q.size()), 64'd0);
    force_busy = 1'b0;
    wait_done("t3", 500, 1'b0);
    check_job("t3", 5, 2, 10, 2);

    // Single-beat job; done follows the PE returning to idle.
    clear_mon();
    start_job(100, 0, 200, 0);
    wait_done("t4", 500, 1'b0);
    check_job("t4", 100, 0, 200, 0);
    chk("t4 done_after_idle", 64'(done_cyc - last_hs_cyc), 64'd5);

    // Start pulsed mid-run with other config is ignored.
    clear_mon();
    start_job(5, 2, 10, 2);
    n = 0;
    while (first_ren_cyc < 0 && n < 100) begin @(posedge clk); #1; n++; end
    chk("t5 run_reached", 64'(first_ren_cyc >= 0), 64'd1);
    cfg_act_base = 10'd300; cfg_act_lst = 10'd1; cfg_wei_base = 8'd40; cfg_wei_lst = 3'd1;
    ctrl_start = 1'b1;
    @(posedge clk); #1;
    ctrl_start = 1'b0;
    wait_done("t5", 500, 1'b0);
    check_job("t5", 5, 2, 10, 2);

    // Activation address wrap at the top of the 10-bit space.
    clear_mon();
    start_job(1022, 3, 7, 0);
    wait_done("t6", 500, 1'b0);
    check_job("t6", 1022, 3, 7, 0);

    // Reset mid-run, then a fresh job.
    clear_mon();
    start_job(5, 2, 10, 2);
    n = 0;
    while (beat_q.size() < 3 && n < 100) begin @(posedge clk); #1; n++; end
    chk("t7 beats_before_reset", 64'(beat_q.size() >= 3), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t7 outputs_in_reset", outs_vec(), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_mon();
    start_job(5, 2, 10, 2);
    wait_done("t7", 500, 1'b0);
    check_job("t7", 5, 2, 10, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
